ewb_line_buffer: RTL
====================

Name: ewb_line_buffer

Overview:
- Eviction write buffer between the unified cache's memory port and physical memory; downstream neighbour of the cache.
- Absorbs dirty-line writebacks in one cycle, serves line reads that hit buffered victims, and drains entries to pmem in FIFO order when the cache is idle.
- Cache-facing side uses the same line-granular, hold-until-resp protocol as pmem, so it drops in transparently.

Parameters:
DEPTH, 4, number of 256-bit line entries; power of two, at least 2.
LINE_W, 256, line width in bits.
ADDR_W, 32, address width.
OFFSET_W, 5, line offset bits; cleared on all stored and emitted addresses.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_read  in  1  cache line read request, held until mem_resp
mem_write  in  1  cache line writeback request, held until mem_resp
mem_addr  in  ADDR_W  line address; offset bits ignored
mem_wdata  in  LINE_W  writeback data
mem_rdata  out  LINE_W  read data, valid in the mem_resp cycle
mem_resp  out  1  single-cycle completion pulse
pmem_read  out  1  pmem read, held until pmem_resp
pmem_write  out  1  pmem write, held until pmem_resp
pmem_addr  out  ADDR_W  line-aligned pmem address
pmem_wdata  out  LINE_W  pmem write data
pmem_rdata  in  LINE_W  pmem read data, valid with pmem_resp
pmem_resp  in  1  pmem single-cycle completion
ewb_empty  out  1  no valid entries (debug/flush visibility)

Behaviour:
- Reset, synchronous on rst=1: all entries invalid; head/tail/count = 0; state IDLE; mem_resp, pmem_read, pmem_write = 0; pmem_addr, pmem_wdata, mem_rdata = 0; ewb_empty = 1.
- Reset during an active pmem transaction drops pmem_read/pmem_write the next edge. Buffered data is discarded by design.
- States: IDLE, RESP, PREAD, DRAIN.
- IDLE priority order: mem_write, then mem_read, then drain (count>0), else stay.
- Write hit on a valid, non-draining entry with matching line address: overwrite data in place (coalesce). No new entry. Go to RESP.
- Write miss with count<DEPTH: push at tail, count+1. Go to RESP.
- Write miss with count==DEPTH: go to DRAIN on head, then return to IDLE and re-evaluate.
- Write matching the entry currently draining: not coalesced. Retried after the drain pops it, and pushed as a new entry.
- Read hit on any valid entry, including one draining: mem_rdata <= entry data. Go to RESP. Coalescing guarantees at most one match.
- Read miss: go to PREAD. pmem_read=1, pmem_addr=aligned mem_addr. On pmem_resp, mem_rdata <= pmem_rdata and go to RESP.
- DRAIN: pmem_write=1, pmem_addr/pmem_wdata from the head entry, held stable. On pmem_resp, invalidate head, head+1 mod DEPTH, count-1, go to IDLE.
- An in-flight pmem transaction is never aborted. A request arriving during DRAIN waits for it to finish.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. Requests are ignored in the RESP cycle, because the cache deasserts only after seeing resp.
- Latencies: write 1 cycle (mem_resp the cycle after the request is sampled). Read hit 1 cycle. Read miss is pmem latency + 1.
- pmem_read and pmem_write are never asserted together.
- Head/tail wrap modulo DEPTH. count ranges 0..DEPTH.
- ewb_empty = (count==0), registered.

Decomposition:
- Package ewb_pkg: state enum (IDLE, RESP, PREAD, DRAIN); entry struct (valid, line address [ADDR_W-1:OFFSET_W], data); localparam PTR_W = $clog2(DEPTH).
- Sub-module ewb_storage: circular FIFO plus CAM.
  - Operations: push, pop, coalesce-write.
  - Outputs: parallel address compare giving hit and hit index, excluding the draining head for write matches; head entry outputs.
- Top level holds the FSM and the pmem/mem registers.

Test Plan:
- Write 0x1000 (data A) -> mem_resp exactly 1 cycle later; no pmem activity while the request is held. Drop the request -> DRAIN writes A to 0x1000; ewb_empty=1 after pmem_resp.
- Write 0x2000 (B), then read 0x2000 -> mem_rdata=B with 1-cycle latency; no pmem_read.
- Write 0x3000 (C1), then write 0x3000 (C2) back-to-back -> count stays 1; the single drain writes C2.
- Fill four lines 0x4000–0x4060, then write 0x5000 -> head 0x4000 drains first, then 0x5000 is accepted. Final drain order: 0x4020, 0x4040, 0x4060, 0x5000.
- Read 0x7000 (miss) while 0x6000 is draining -> pmem_write completes first, then pmem_read 0x7000; mem_rdata equals pmem_rdata; never both pmem strobes high.
- Assert rst mid-DRAIN -> pmem_write=0 next cycle; ewb_empty=1; a following read 0x6000 goes to pmem.

Source files
------------

// File: rtl/ewb_pkg.sv
// ewb_pkg: shared types and geometry for the eviction write buffer.
// Holds the FSM state enum, the buffered-entry struct and widths.
package ewb_pkg;

  localparam int EWB_DEPTH = 4;
  localparam int LINE_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int OFFSET_W  = 5;
  localparam int PTR_W     = $clog2(EWB_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    PREAD,
    DRAIN
  } state_t;

  typedef logic [ADDR_W-1:OFFSET_W] tag_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [LINE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/ewb_storage.sv
// ewb_storage: circular line FIFO with a parallel address CAM.
// Ports: push/pop/cwr strobes, tag+wdata in; hit flags, head entry, full/empty out.
module ewb_storage
  import ewb_pkg::*;
#(
  parameter int DEPTH = EWB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  tag_t                     tag,
  input  logic [LINE_W-1:0]        wdata,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     cwr,
  input  logic                     draining,
  output logic                     wr_hit,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic                     rd_hit,
  output logic [LINE_W-1:0]        rd_data,
  output tag_t                     head_tag,
  output logic [LINE_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        ent [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW:0]   count_n;

  assign head_tag  = ent[head].tag;
  assign head_data = ent[head].data;
  assign full      = (count == (PW+1)'(DEPTH));

  // Reads may hit the draining head; writes must not coalesce
  // into it, since its data is already on the pmem bus.
  always_comb begin
    wr_hit  = 1'b0;
    wr_idx  = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[i].valid && ent[i].tag == tag) begin
        rd_hit  = 1'b1;
        rd_data = ent[i].data;
        if (!(draining && PW'(i) == head)) begin
          wr_hit = 1'b1;
          wr_idx = PW'(i);
        end
      end
    end
  end

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + 1'b1;
    else if (pop && !push)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (push) begin
        ent[tail] <= '{valid: 1'b1, tag: tag, data: wdata};
        tail      <= tail + 1'b1;
      end
      if (cwr)
        ent[wr_idx].data <= wdata;
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count_n;
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/ewb_line_buffer.sv
// ewb_line_buffer: eviction write buffer between cache and pmem.
// Ports: mem_* cache side, pmem_* memory side, ewb_empty status.
module ewb_line_buffer
  import ewb_pkg::*;
#(
  parameter int DEPTH = EWB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              ewb_empty
);

  localparam int PW = $clog2(DEPTH);

  state_t            state, state_n;
  logic              mem_resp_n;
  logic [LINE_W-1:0] mem_rdata_n;
  logic              pmem_read_n;
  logic              pmem_write_n;
  logic [ADDR_W-1:0] pmem_addr_n;
  logic [LINE_W-1:0] pmem_wdata_n;

  tag_t              tag;
  logic              push, pop, cwr;
  logic              wr_hit, rd_hit;
  logic [PW-1:0]     wr_idx;
  logic [LINE_W-1:0] rd_data;
  tag_t              head_tag;
  logic [LINE_W-1:0] head_data;
  logic              full;
  logic              unused_off;

  assign tag        = mem_addr[ADDR_W-1:OFFSET_W];
  assign unused_off = ^mem_addr[OFFSET_W-1:0];

  ewb_storage #(.DEPTH(DEPTH)) u_storage (
    .clk       (clk),
    .rst       (rst),
    .tag       (tag),
    .wdata     (mem_wdata),
    .push      (push),
    .pop       (pop),
    .cwr       (cwr),
    .draining  (state == DRAIN),
    .wr_hit    (wr_hit),
    .wr_idx    (wr_idx),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .head_tag  (head_tag),
    .head_data (head_data),
    .full      (full),
    .empty     (ewb_empty)
  );

  always_comb begin
    state_n      = state;
    mem_resp_n   = 1'b0;
    mem_rdata_n  = mem_rdata;
    pmem_read_n  = pmem_read;
    pmem_write_n = pmem_write;
    pmem_addr_n  = pmem_addr;
    pmem_wdata_n = pmem_wdata;
    push         = 1'b0;
    pop          = 1'b0;
    cwr          = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_write) begin
          if (wr_hit) begin
            cwr        = 1'b1;
            mem_resp_n = 1'b1;
            state_n    = RESP;
          end else if (!full) begin
            push       = 1'b1;
            mem_resp_n = 1'b1;
            state_n    = RESP;
          end else begin
            // Make room; the write is re-evaluated back in IDLE.
            pmem_write_n = 1'b1;
            pmem_addr_n  = {head_tag, {OFFSET_W{1'b0}}};
            pmem_wdata_n = head_data;
            state_n      = DRAIN;
          end
        end else if (mem_read) begin
          if (rd_hit) begin
            mem_rdata_n = rd_data;
            mem_resp_n  = 1'b1;
            state_n     = RESP;
          end else begin
            pmem_read_n = 1'b1;
            pmem_addr_n = {tag, {OFFSET_W{1'b0}}};
            state_n     = PREAD;
          end
        end else if (!ewb_empty) begin
          pmem_write_n = 1'b1;
          pmem_addr_n  = {head_tag, {OFFSET_W{1'b0}}};
          pmem_wdata_n = head_data;
          state_n      = DRAIN;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      PREAD: begin
        if (pmem_resp) begin
          mem_rdata_n = pmem_rdata;
          pmem_read_n = 1'b0;
          mem_resp_n  = 1'b1;
          state_n     = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pop          = 1'b1;
          pmem_write_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_resp   <= 1'b0;
      mem_rdata  <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
    end else begin
      state      <= state_n;
      mem_resp   <= mem_resp_n;
      mem_rdata  <= mem_rdata_n;
      pmem_read  <= pmem_read_n;
      pmem_write <= pmem_write_n;
      pmem_addr  <= pmem_addr_n;
      pmem_wdata <= pmem_wdata_n;
    end
  end

endmodule
